// File: rtl/cmplx_mac_seq_pkg.sv
// Shared types for the sequential complex MAC.
//   state_t   : FSM encoding. IDLE, four product steps P0..P3, then DONE.
//   next_step : successor of a product step. P3 goes to DONE.
package cmplx_mac_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  function automatic state_t next_step(state_t s);
    case (s)
      ST_P0:   return ST_P1;
      ST_P1:   return ST_P2;
      ST_P2:   return ST_P3;
      ST_P3:   return ST_DONE;
      default: return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/cmplx_mac_seq_if.sv
// Request/result bus of the complex MAC.
//   start/acc_en/clr/a/b : request side, driven by the master.
//   busy/done/out/ovf    : status and result, driven by the MAC (slave).
//   a = {ar, ai}, b = {br, bi}, out = {acc_re, acc_im}.
interface cmplx_mac_seq_if #(
  parameter int W     = 4,
  parameter int ACC_W = 2*W+4
);
  logic               start;
  logic               acc_en;
  logic               clr;
  logic [2*W-1:0]     a;
  logic [2*W-1:0]     b;
  logic               busy;
  logic               done;
  logic [2*ACC_W-1:0] out;
  logic               ovf;

  modport master (output start, acc_en, clr, a, b,
                  input  busy, done, out, ovf);
  modport slave  (input  start, acc_en, clr, a, b,
                  output busy, done, out, ovf);
endinterface

// File: rtl/cmplx_mac_seq_mult.sv
// mult_wxw_signed: combinational W x W -> 2W signed multiplier.
//   x, y : signed operands
//   p    : signed full-width product
module mult_wxw_signed #(
  parameter int W = 4
) (
  input  logic signed [W-1:0]   x,
  input  logic signed [W-1:0]   y,
  output logic signed [2*W-1:0] p
);
  // Explicit sign extension keeps the multiply at full product width.
  logic signed [2*W-1:0] xe, ye;
  assign xe = {{W{x[W-1]}}, x};
  assign ye = {{W{y[W-1]}}, y};
  assign p  = xe * ye;
endmodule

// File: rtl/cmplx_mac_seq.sv
// cmplx_mac_seq: sequential complex multiply-accumulate.
// (ar + j*ai)*(br + j*bi) is formed over four steps on one shared multiplier
// and one shared ACC_W adder/subtractor, then added into (or replaces)
// the real/imag accumulators.
//   clk : rising-edge clock
//   rst : asynchronous reset, active low
//   bus : slave side of cmplx_mac_seq_if (start/acc_en/clr/a/b in,
//         busy/done/out/ovf out)
// SAT=1 clamps an overflowing step to +max/-min; SAT=0 wraps. Either way
// the sticky ovf flag is set.
module cmplx_mac_seq
  import cmplx_mac_seq_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 2*W+4,
  parameter bit SAT   = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  cmplx_mac_seq_if.slave bus
);

  state_t                state;
  logic signed [W-1:0]   ar, ai, br, bi;
  logic [ACC_W-1:0]      acc_re, acc_im;
  logic                  busy_q, done_q, ovf_q;

  // Operand steering onto the shared multiplier.
  logic signed [W-1:0]   mx, my;
  logic signed [2*W-1:0] prod;

  always_comb begin
    mx = ar;
    my = br;
    case (state)
      ST_P1:   begin mx = ai; my = bi; end
      ST_P2:   begin mx = ar; my = bi; end
      ST_P3:   begin mx = ai; my = br; end
      default: ;
    endcase
  end

  mult_wxw_signed #(.W(W)) u_mult (.x(mx), .y(my), .p(prod));

  // Shared adder: P0/P1 target acc_re, P2/P3 target acc_im; P1 subtracts
  // by inverting the addend and injecting a carry.
  logic             sel_re, sub, step_ovf;
  logic [ACC_W-1:0] acc_cur, addend, sum, res;

  assign sel_re  = (state == ST_P0) || (state == ST_P1);
  assign sub     = (state == ST_P1);
  assign acc_cur = sel_re ? acc_re : acc_im;
  assign addend  = {{(ACC_W-2*W){prod[2*W-1]}}, prod} ^ {ACC_W{sub}};
  assign sum     = acc_cur + addend + {{(ACC_W-1){1'b0}}, sub};
  // Checked on the inverted addend, this is exact for subtraction as well.
  assign step_ovf = (acc_cur[ACC_W-1] == addend[ACC_W-1]) &&
                    (sum[ACC_W-1]     != acc_cur[ACC_W-1]);

  always_comb begin
    res = sum;
    if (SAT && step_ovf)
      res = acc_cur[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      ar     <= '0;
      ai     <= '0;
      br     <= '0;
      bi     <= '0;
      acc_re <= '0;
      acc_im <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (bus.clr) begin
      // clr wins over start and aborts any step in flight.
      state  <= ST_IDLE;
      acc_re <= '0;
      acc_im <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            {ar, ai} <= bus.a;
            {br, bi} <= bus.b;
            if (!bus.acc_en) begin
              acc_re <= '0;
              acc_im <= '0;
              ovf_q  <= 1'b0;
            end
            state  <= ST_P0;
            busy_q <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_P0, ST_P1, ST_P2, ST_P3: begin
          if (sel_re) acc_re <= res;
          else        acc_im <= res;
          if (step_ovf) ovf_q <= 1'b1;
          state <= next_step(state);
          if (state == ST_P3) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.out  = {acc_re, acc_im};

endmodule

// File: tb/tb_cmplx_mac_seq.sv
// Directed bench for cmplx_mac_seq. Three instances share one stimulus:
// W=4/ACC_W=12/SAT=0 (main), W=4/ACC_W=8 with SAT=1 and with SAT=0.
module tb_cmplx_mac_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, acc_en = 1'b0, clr = 1'b0;
  logic [7:0] a = '0, b = '0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  cmplx_mac_seq_if #(.W(4), .ACC_W(12)) if12 ();
  cmplx_mac_seq_if #(.W(4), .ACC_W(8))  if8s ();
  cmplx_mac_seq_if #(.W(4), .ACC_W(8))  if8w ();

  assign if12.start = start; assign if12.acc_en = acc_en; assign if12.clr = clr;
  assign if12.a = a;         assign if12.b = b;
  assign if8s.start = start; assign if8s.acc_en = acc_en; assign if8s.clr = clr;
  assign if8s.a = a;         assign if8s.b = b;
  assign if8w.start = start; assign if8w.acc_en = acc_en; assign if8w.clr = clr;
  assign if8w.a = a;         assign if8w.b = b;

  cmplx_mac_seq #(.W(4), .ACC_W(12), .SAT(1'b0)) u12  (.clk(clk), .rst(rst), .bus(if12));
  cmplx_mac_seq #(.W(4), .ACC_W(8),  .SAT(1'b1)) u8s  (.clk(clk), .rst(rst), .bus(if8s));
  cmplx_mac_seq #(.W(4), .ACC_W(8),  .SAT(1'b0)) u8w  (.clk(clk), .rst(rst), .bus(if8w));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accept edge; returns just after it.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic ae);
    start = 1'b1; acc_en = ae; a = av; b = bv;
    tick();
    start = 1'b0; acc_en = 1'b0;
  endtask

  // Edges from the accept edge until done; 20 means it never came.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!if12.done && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (if12.out !== 24'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", if12.out); end
    checks++; if ({if12.busy, if12.done, if12.ovf} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got=%b exp=000", {if12.busy, if12.done, if12.ovf}); end
    @(negedge clk); rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    launch(8'h32, 8'h14, 1'b0);           // (3+2j)*(1+4j) = -5+14j
    wait_done(lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL latency got=%0d exp=4", lat); end
    checks++; if (if12.out !== {12'hFFB, 12'h00E}) begin errors++; $display("FAIL basic_out got=%h exp=ffb00e", if12.out); end
    checks++; if (if12.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got=%b exp=0", if12.ovf); end
  endtask

  task automatic test_accumulate();
    int lat;
    launch(8'h32, 8'h14, 1'b1);
    wait_done(lat);
    checks++; if (if12.out !== {12'hFF6, 12'h01C}) begin errors++; $display("FAIL acc_out got=%h exp=ff601c", if12.out); end
    launch(8'h00, 8'h14, 1'b0);
    wait_done(lat);
    checks++; if (if12.out !== 24'h0) begin errors++; $display("FAIL acc_clear got=%h exp=0", if12.out); end
  endtask

  // (-8-8j)^2 = 0+128j; also the 8-bit overflow cases.
  task automatic test_extreme_overflow();
    int bcnt, dcnt;
    launch(8'h88, 8'h88, 1'b0);
    bcnt = int'(if12.busy); dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      bcnt += int'(if12.busy);
      dcnt += int'(if12.done);
    end
    checks++; if (bcnt !== 4) begin errors++; $display("FAIL busy_len got=%0d exp=4", bcnt); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL done_pulses got=%0d exp=1", dcnt); end
    checks++; if (if12.out !== {12'h000, 12'h080}) begin errors++; $display("FAIL ext12_out got=%h exp=000080", if12.out); end
    checks++; if (if12.ovf !== 1'b0) begin errors++; $display("FAIL ext12_ovf got=%b exp=0", if12.ovf); end
    checks++; if (if8s.out !== 16'h007F) begin errors++; $display("FAIL sat_out got=%h exp=007f", if8s.out); end
    checks++; if (if8s.ovf !== 1'b1) begin errors++; $display("FAIL sat_ovf got=%b exp=1", if8s.ovf); end
    checks++; if (if8w.out !== 16'h0080) begin errors++; $display("FAIL wrap_out got=%h exp=0080", if8w.out); end
    checks++; if (if8w.ovf !== 1'b1) begin errors++; $display("FAIL wrap_ovf got=%b exp=1", if8w.ovf); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if ({if8s.out, if8s.ovf, if8w.ovf} !== 18'h0) begin errors++;
      $display("FAIL clr_ovf got=%h exp=0", {if8s.out, if8s.ovf, if8w.ovf}); end
  endtask

  task automatic test_back_to_back();
    int d1, d2, lat;
    logic [23:0] out2;
    d1 = -1; d2 = -1; out2 = '0;
    start = 1'b1; acc_en = 1'b1; a = 8'h32; b = 8'h14;
    tick();                               // accept edge, index 0
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 5) begin start = 1'b0; acc_en = 1'b0; end
      if (if12.done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) begin d2 = i; out2 = if12.out; end
      end
    end
    checks++; if (d1 !== 4 || d2 !== 9) begin errors++; $display("FAIL b2b_spacing got=%0d,%0d exp=4,9", d1, d2); end
    checks++; if (out2 !== {12'hFF6, 12'h01C}) begin errors++; $display("FAIL b2b_out got=%h exp=ff601c", out2); end
    // start pulsed in P2 must be ignored
    launch(8'h32, 8'h14, 1'b0);
    tick(); tick();                       // now in P2
    start = 1'b1; a = 8'h88; b = 8'h88;
    tick();
    start = 1'b0;
    wait_done(lat);
    checks++; if (lat !== 1 || if12.out !== {12'hFFB, 12'h00E}) begin errors++;
      $display("FAIL start_in_p2 got=%0d/%h exp=1/ffb00e", lat, if12.out); end
    tick();
    checks++; if ({if12.busy, if12.done} !== 2'b00) begin errors++;
      $display("FAIL no_requeue got=%b exp=00", {if12.busy, if12.done}); end
  endtask

  task automatic test_abort();
    int lat, dcnt;
    launch(8'h32, 8'h14, 1'b0);
    tick(); tick();                       // in P2, acc_re already nonzero
    #1 rst = 1'b0;
    #1;
    checks++; if (if12.out !== 24'h0 || if12.busy !== 1'b0) begin errors++;
      $display("FAIL async_rst got=%h/%b exp=0/0", if12.out, if12.busy); end
    #1 rst = 1'b1;
    tick();
    checks++; if (if12.busy !== 1'b0) begin errors++; $display("FAIL rst_idle got=%b exp=0", if12.busy); end
    // clr and start on the same edge
    launch(8'h32, 8'h14, 1'b0);
    wait_done(lat);
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    tick();
    checks++; if (if12.busy !== 1'b0 || if12.out !== 24'h0) begin errors++;
      $display("FAIL clr_beats_start got=%b/%h exp=0/0", if12.busy, if12.out); end
    // clr while in P1
    launch(8'h32, 8'h14, 1'b0);
    tick();
    clr = 1'b1; tick(); clr = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      dcnt += int'(if12.done) + int'(if12.busy);
      tick();
    end
    checks++; if (dcnt !== 0 || if12.out !== 24'h0) begin errors++;
      $display("FAIL clr_in_p1 got=%0d/%h exp=0/0", dcnt, if12.out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_extreme_overflow();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
